multicycle_control_fsm: RTL

- Sequencing controller for the multi-cycle MIPS datapath.
- Produces the control-bus signals (rf_we, sel_wa, sel_alu_b, dmem_we, sel_result, sel_pc, alu_op) that the decode/ControlBus checks consume, plus PC/IR enables and a shared-memory request/ready handshake.
- Steps each instruction through fetch, decode, execute, memory and writeback states, driven by opcode, ALU zero and memory ready.

---
 rtl/multicycle_control_fsm.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Sequencing controller for the multi-cycle MIPS datapath. Each instruction
//   steps through fetch, decode, execute, memory and writeback states. Most
//   outputs are decoded from the registered state (Moore). A few depend on
//   inputs in the current cycle (Mealy):
//     - ir_we and pc_we in FETCH
//     - pc_we in BRANCH
//     - retire and illegal_op
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (forces IDLE)
//   opcode     in   instr[31:26]; sampled only in DECODE and MEMADR
//   zero       in   ALU zero flag, qualifies pc_we in BRANCH
//   mem_ready  in   memory accepted/completed the current request
//   mem_req    out  memory request
//   mem_we     out  memory write
//   iord       out  address select: 0 = PC, 1 = ALUOut
//   ir_we      out  instruction register load
//   pc_we      out  PC load
//   rf_we      out  register file write
//   sel_wa     out  write address: 0 = rt, 1 = rd, 2 = RA_INDEX
//   sel_alu_a  out  ALU A: 0 = PC, 1 = rs
//   sel_alu_b  out  ALU B: 0 = rt, 1 = 4, 2 = sign_imm, 3 = sign_imm<<2
//   sel_result out  writeback data: 0 = ALUOut, 1 = mem data, 2 = PC
//   sel_pc     out  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target
//   alu_op     out  0 = add, 1 = sub, 2 = funct-decoded
//   retire     out  pulse in the final cycle of each instruction
//   illegal_op out  pulse in DECODE on an unknown opcode
//   state      out  current state code, for debug
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int RA_INDEX = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic [1:0] sel_wa,
  output logic       sel_alu_a,
  output logic [1:0] sel_alu_b,
  output logic [1:0] sel_result,
  output logic [1:0] sel_pc,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_ADDIEX = 4'd8;
  localparam logic [3:0] S_ADDIWB = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;
  localparam logic [3:0] S_IDLE   = 4'd13;

  // RA_INDEX only documents which register sel_wa=2 addresses; the datapath
  // owns the actual mux, so the value is folded into a deliberately dead net.
  logic unused_ra_index;
  assign unused_ra_index = ^5'(RA_INDEX);

  logic [3:0] state_q;
  logic [3:0] state_d;

  // State register. Reset is asynchronous so an in-flight memory request
  // is dropped without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_JAL:    state_d = S_FETCH;
      default:  state_d = S_IDLE;  // unused codes 14/15 recover via IDLE
    endcase
  end

  // Output decode
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    sel_wa     = 2'd0;
    sel_alu_a  = 1'b0;
    sel_alu_b  = 2'd0;
    sel_result = 2'd0;
    sel_pc     = 2'd0;
    alu_op     = 2'd0;
    retire     = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        sel_alu_b = 2'd1;
        // IR and PC+4 commit only in the cycle memory delivers the word.
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE: begin
        sel_alu_b = 2'd3;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J, OP_JAL: ;
          default: begin
            illegal_op = 1'b1;
            retire     = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        sel_alu_a = 1'b1;
        sel_alu_b = 2'd2;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        rf_we      = 1'b1;
        sel_result = 2'd1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        retire  = mem_ready;
      end
      S_EXEC: begin
        sel_alu_a = 1'b1;
        alu_op    = 2'd2;
      end
      S_ALUWB: begin
        rf_we  = 1'b1;
        sel_wa = 2'd1;
        retire = 1'b1;
      end
      S_ADDIEX: begin
        sel_alu_a = 1'b1;
        sel_alu_b = 2'd2;
      end
      S_ADDIWB: begin
        rf_we  = 1'b1;
        retire = 1'b1;
      end
      S_BRANCH: begin
        sel_alu_a = 1'b1;
        alu_op    = 2'd1;
        sel_pc    = 2'd1;
        pc_we     = zero;
        retire    = 1'b1;
      end
      S_JUMP: begin
        sel_pc = 2'd2;
        pc_we  = 1'b1;
        retire = 1'b1;
      end
      S_JAL: begin
        rf_we      = 1'b1;
        sel_wa     = 2'd2;
        sel_result = 2'd2;  // PC already holds the return address (PC+4)
        sel_pc     = 2'd2;
        pc_we      = 1'b1;
        retire     = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule
